issue_scheduler: RTL

Sits between the rename stage and the issue bus. Buffers renamed instructions in a small in-order FIFO, then issues the oldest one per cycle onto the shared issue bus. It issues only when the targeted reservation station and the ROB can both accept. It also counts head-of-queue stall cycles for performance monitoring.

---
 rtl/issue_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// In-order issue buffer between rename and the shared issue bus: holds renamed
// instructions in a small FIFO and issues the head once its station and the ROB can take it.
module issue_scheduler #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int FLAGS_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_address,
  input  logic [XLEN-1:0]            in_immediate,
  input  logic [5:0]                 in_src_1,
  input  logic [5:0]                 in_src_2,
  input  logic [5:0]                 in_arn,
  input  logic [5:0]                 in_rrn,
  input  logic [FLAGS_W-1:0]         in_flags,
  input  logic [1:0]                 in_st_type,
  input  logic [3:0]                 st_ready,
  input  logic                       rob_ready,
  output logic [3:0]                 issue_valid,
  output logic [XLEN-1:0]            issue_address,
  output logic [XLEN-1:0]            issue_immediate,
  output logic [5:0]                 issue_src_1,
  output logic [5:0]                 issue_src_2,
  output logic [5:0]                 issue_arn,
  output logic [5:0]                 issue_rrn,
  output logic [FLAGS_W-1:0]         issue_flags,
  output logic                       rob_push,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                stall_cycles
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    address;
    logic [XLEN-1:0]    immediate;
    logic [5:0]         src_1;
    logic [5:0]         src_2;
    logic [5:0]         arn;
    logic [5:0]         rrn;
    logic [FLAGS_W-1:0] flags;
    logic [1:0]         st_type;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, fire, head_valid;

  assign in_entry = '{address: in_address, immediate: in_immediate, src_1: in_src_1,
                      src_2: in_src_2, arn: in_arn, rrn: in_rrn, flags: in_flags,
                      st_type: in_st_type};

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);
  // No pass-through: a full queue refuses input even if the head fires this cycle.
  assign in_ready   = (count < (AW+1)'(DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  assign fire       = head_valid && st_ready[head.st_type] && rob_ready && !flush;

  assign issue_valid     = fire ? (4'b0001 << head.st_type) : 4'b0000;
  assign rob_push        = fire;
  assign issue_address   = head.address;
  assign issue_immediate = head.immediate;
  assign issue_src_1     = head.src_1;
  assign issue_src_2     = head.src_2;
  assign issue_arn       = head.arn;
  assign issue_rrn       = head.rrn;
  assign issue_flags     = head.flags;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (fire) rd_ptr <= rd_ptr + AW'(1);
      case ({push, fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Performance counter survives flushes; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (head_valid && !fire && !flush && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule
